cpu_ctrl_seq: RTL and testbench

Parametrised multi-cycle accumulator CPU control sequencer. It fetches instruction words from an external memory over a req/ack handshake and decodes {opcode, obj}. It executes against two data registers R1/R2 and Z/C flags. It is the next generation of the team's single-cycle-decode instruction controller, adding configurable widths, a memory handshake, conditional jumps, HALT and illegal-opcode detection.

---
 rtl/cpu_ctrl_seq_if.sv | 23 ++
 rtl/cpu_ctrl_seq.sv | 180 ++++++++++++++++++
 tb/tb_cpu_ctrl_seq.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_seq_if.sv
// Memory request/acknowledge bundle between the sequencer (master) and an
// instruction/data memory (slave).
interface cpu_ctrl_seq_if #(
  parameter int AW = 11,
  parameter int IW = 16
);
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [IW-1:0] mem_wdata;
  logic [IW-1:0] mem_rdata;
  logic          mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/cpu_ctrl_seq.sv
// Multi-cycle accumulator CPU sequencer: fetch/decode/execute over a req/ack
// memory port, two data registers, Z/C flags, sticky HALT and illegal status.
module cpu_ctrl_seq #(
  parameter int DW  = 8,
  parameter int AW  = 11,
  parameter int OPW = 5
) (
  input  logic           clk,
  input  logic           rst_clk,
  cpu_ctrl_seq_if.master mem,
  output logic [DW-1:0]  out_data,
  output logic           out_valid,
  output logic [AW-1:0]  pc,
  output logic [DW-1:0]  r1,
  output logic [DW-1:0]  r2,
  output logic           flag_z,
  output logic           flag_c,
  output logic           halted,
  output logic           illegal
);

  localparam int IW = OPW + AW;
  localparam int HW = DW / 2;

  localparam logic [OPW-1:0] OP_NOP  = OPW'(0);
  localparam logic [OPW-1:0] OP_LDA  = OPW'(1);
  localparam logic [OPW-1:0] OP_ADD  = OPW'(2);
  localparam logic [OPW-1:0] OP_OUT  = OPW'(3);
  localparam logic [OPW-1:0] OP_STR  = OPW'(4);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(5);
  localparam logic [OPW-1:0] OP_JMP  = OPW'(6);
  localparam logic [OPW-1:0] OP_SWAP = OPW'(7);
  localparam logic [OPW-1:0] OP_SDL  = OPW'(8);
  localparam logic [OPW-1:0] OP_SDH  = OPW'(9);
  localparam logic [OPW-1:0] OP_JZ   = OPW'(10);
  localparam logic [OPW-1:0] OP_JC   = OPW'(11);
  localparam logic [OPW-1:0] OP_HALT = OPW'(31);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  state_t        state_q;
  logic [AW-1:0] pc_q;
  logic [IW-1:0] ir_q;
  logic [DW-1:0] r1_q;
  logic [DW-1:0] r2_q;
  logic          z_q;
  logic          c_q;
  logic [DW-1:0] out_data_q;
  logic          out_valid_q;
  logic          halted_q;
  logic          illegal_q;

  logic [OPW-1:0] opcode;
  logic [AW-1:0]  obj;
  logic [DW-1:0]  operand;
  logic [DW:0]    add_d;
  logic [DW:0]    sub_d;
  logic           req_state;

  assign opcode  = ir_q[IW-1:AW];
  assign obj     = ir_q[AW-1:0];
  assign operand = mem.mem_rdata[DW-1:0];

  // Extra MSB of the subtraction is the borrow: set exactly when R1 < operand.
  assign add_d = {1'b0, r1_q} + {1'b0, operand};
  assign sub_d = {1'b0, r1_q} - {1'b0, operand};

  // Gating with rst_clk drops the request the instant reset asserts, even
  // though the reset state is FETCH; the first fetch starts right after release.
  assign req_state     = (state_q == S_FETCH) || (state_q == S_MEM);
  assign mem.mem_req   = rst_clk & req_state;
  assign mem.mem_we    = (state_q == S_MEM) && (opcode == OP_STR);
  assign mem.mem_addr  = (state_q == S_MEM) ? obj : pc_q;
  assign mem.mem_wdata = IW'(r1_q);

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign pc        = pc_q;
  assign r1        = r1_q;
  assign r2        = r2_q;
  assign flag_z    = z_q;
  assign flag_c    = c_q;
  assign halted    = halted_q;
  assign illegal   = illegal_q;

  always_ff @(posedge clk or negedge rst_clk) begin
    if (!rst_clk) begin
      state_q     <= S_FETCH;
      pc_q        <= '0;
      ir_q        <= '0;
      r1_q        <= '0;
      r2_q        <= '0;
      z_q         <= 1'b0;
      c_q         <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      halted_q    <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      unique case (state_q)
        S_FETCH: begin
          if (mem.mem_ack) begin
            ir_q    <= mem.mem_rdata;
            state_q <= S_DECODE;
          end
        end

        S_DECODE: begin
          pc_q    <= pc_q + AW'(1);
          state_q <= S_EXEC;
        end

        S_EXEC: begin
          state_q <= S_FETCH;
          unique case (opcode)
            OP_NOP: ;
            OP_LDA, OP_ADD, OP_SUB, OP_STR: state_q <= S_MEM;
            OP_OUT: begin
              out_data_q  <= r1_q;
              out_valid_q <= 1'b1;
            end
            OP_JMP: pc_q <= obj;
            OP_SWAP: begin
              r1_q <= r2_q;
              r2_q <= r1_q;
            end
            OP_SDL: r2_q[HW-1:0]  <= obj[HW-1:0];
            OP_SDH: r2_q[DW-1:HW] <= obj[HW-1:0];
            OP_JZ: begin
              if (z_q) pc_q <= obj;
            end
            OP_JC: begin
              if (c_q) pc_q <= obj;
            end
            OP_HALT: begin
              state_q  <= S_HALT;
              halted_q <= 1'b1;
            end
            default: illegal_q <= 1'b1;
          endcase
        end

        S_MEM: begin
          if (mem.mem_ack) begin
            state_q <= S_FETCH;
            unique case (opcode)
              OP_LDA: begin
                r1_q <= operand;
                z_q  <= (operand == '0);
              end
              OP_ADD: begin
                r1_q <= add_d[DW-1:0];
                c_q  <= add_d[DW];
                z_q  <= (add_d[DW-1:0] == '0);
              end
              OP_SUB: begin
                r1_q <= sub_d[DW-1:0];
                c_q  <= sub_d[DW];
                z_q  <= (sub_d[DW-1:0] == '0);
              end
              default: ;
            endcase
          end
        end

        S_HALT: state_q <= S_HALT;

        default: state_q <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// Self-checking bench for cpu_ctrl_seq: table of ALU programs plus hand-built
// sequences; OUT values and memory writes are checked through scoreboards.
module tb_cpu_ctrl_seq;
  localparam int DW  = 8;
  localparam int AW  = 11;
  localparam int OPW = 5;
  localparam int IW  = OPW + AW;

  localparam logic [4:0] OP_NOP  = 5'd0;
  localparam logic [4:0] OP_LDA  = 5'd1;
  localparam logic [4:0] OP_ADD  = 5'd2;
  localparam logic [4:0] OP_OUT  = 5'd3;
  localparam logic [4:0] OP_STR  = 5'd4;
  localparam logic [4:0] OP_SUB  = 5'd5;
  localparam logic [4:0] OP_JMP  = 5'd6;
  localparam logic [4:0] OP_SWAP = 5'd7;
  localparam logic [4:0] OP_SDL  = 5'd8;
  localparam logic [4:0] OP_SDH  = 5'd9;
  localparam logic [4:0] OP_JZ   = 5'd10;
  localparam logic [4:0] OP_JC   = 5'd11;
  localparam logic [4:0] OP_BAD  = 5'h15;
  localparam logic [4:0] OP_HALT = 5'd31;

  logic clk = 1'b0;
  logic rst_clk;
  always #5 clk = ~clk;

  logic [DW-1:0] out_data;
  logic          out_valid;
  logic [AW-1:0] pc;
  logic [DW-1:0] r1, r2;
  logic          flag_z, flag_c, halted, illegal;

  cpu_ctrl_seq_if #(.AW(AW), .IW(IW)) mif ();

  cpu_ctrl_seq #(.DW(DW), .AW(AW), .OPW(OPW)) dut (
    .clk       (clk),
    .rst_clk   (rst_clk),
    .mem       (mif),
    .out_data  (out_data),
    .out_valid (out_valid),
    .pc        (pc),
    .r1        (r1),
    .r2        (r2),
    .flag_z    (flag_z),
    .flag_c    (flag_c),
    .halted    (halted),
    .illegal   (illegal)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory model with programmable wait states and an optional address that never acks.
  logic [IW-1:0] mem_arr [0:(1<<AW)-1];
  int            wait_n = 0;
  int            req_cnt = 0;
  bit            block_en = 1'b0;
  logic [AW-1:0] block_addr = '0;

  assign mif.mem_ack   = mif.mem_req && (req_cnt >= wait_n) &&
                         !(block_en && (mif.mem_addr == block_addr));
  assign mif.mem_rdata = mem_arr[mif.mem_addr];

  always @(posedge clk) begin
    if (mif.mem_req && !mif.mem_ack) req_cnt <= req_cnt + 1;
    else                             req_cnt <= 0;
  end

  typedef struct {
    logic [AW-1:0] addr;
    logic [IW-1:0] data;
  } wr_t;

  logic [DW-1:0] exp_out [$];
  wr_t           exp_wr [$];
  logic [AW-1:0] addr_log [$];
  bit            log_en = 1'b0;
  int            wait_cycles = 0;
  int            stab_err = 0;
  bit            hold_v = 1'b0;
  logic [AW-1:0] hold_addr;
  logic          hold_we;

  always @(negedge clk) begin
    if (rst_clk && out_valid) begin
      if (exp_out.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out_unexpected: got %0h expected no pulse", out_data);
      end else begin
        check("out_data", 32'(out_data), 32'(exp_out.pop_front()));
      end
    end
    if (mif.mem_req && mif.mem_ack) begin
      if (log_en) addr_log.push_back(mif.mem_addr);
      if (mif.mem_we) begin
        if (exp_wr.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wr_unexpected: got addr %0h expected no write", mif.mem_addr);
        end else begin
          wr_t w;
          w = exp_wr.pop_front();
          check("wr_addr", 32'(mif.mem_addr), 32'(w.addr));
          check("wr_data", 32'(mif.mem_wdata), 32'(w.data));
        end
        mem_arr[mif.mem_addr] = mif.mem_wdata;
      end
    end
    if (mif.mem_req && !mif.mem_ack) begin
      wait_cycles++;
      if (hold_v && (mif.mem_addr != hold_addr || mif.mem_we != hold_we)) stab_err++;
      hold_v    = 1'b1;
      hold_addr = mif.mem_addr;
      hold_we   = mif.mem_we;
    end else begin
      hold_v = 1'b0;
    end
  end

  function automatic logic [IW-1:0] ins(logic [4:0] op, logic [AW-1:0] obj);
    return {op, obj};
  endfunction

  task automatic start_test();
    rst_clk = 1'b0;
    @(negedge clk);
    for (int i = 0; i < (1 << AW); i++) mem_arr[i] = '0;
    exp_out.delete();
    exp_wr.delete();
    addr_log.delete();
    log_en      = 1'b0;
    wait_n      = 0;
    block_en    = 1'b0;
    wait_cycles = 0;
    stab_err    = 0;
  endtask

  task automatic release_and_run(output int edges);
    @(negedge clk);
    rst_clk = 1'b1;
    edges   = 0;
    while (!halted && edges < 2000) begin
      @(posedge clk);
      #1;
      edges++;
    end
    if (!halted) begin
      checks++;
      errors++;
      $display("FAIL halt_timeout: got %0d edges expected halt", edges);
    end
  endtask

  typedef struct {
    logic [4:0]    op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] exp_r1;
    logic          exp_z;
    logic          exp_c;
  } alu_vec_t;

  alu_vec_t vecs [7];

  initial begin
    int edges;
    logic [AW-1:0] exp_addrs [6];

    vecs[0] = '{OP_ADD, 8'h05, 8'hFE, 8'h03, 1'b0, 1'b1};
    vecs[1] = '{OP_SUB, 8'h40, 8'h40, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{OP_SUB, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b1};
    vecs[3] = '{OP_ADD, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
    vecs[4] = '{OP_ADD, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0};
    vecs[5] = '{OP_LDA, 8'h5A, 8'h00, 8'h00, 1'b1, 1'b0};
    vecs[6] = '{OP_SUB, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b1};

    start_test();
    check("rst_pc", 32'(pc), 32'h0);
    check("rst_regs", {16'h0, r1, r2}, 32'h0);
    check("rst_req", {28'h0, mif.mem_req, mif.mem_we, out_valid, halted}, 32'h0);
    check("rst_flags", {29'h0, flag_z, flag_c, illegal}, 32'h0);

    // LDA 0x10, <op> 0x11, OUT, HALT: 4 + 4 + 3 + 3 edges, halted in cycle 15.
    for (int i = 0; i < 7; i++) begin
      start_test();
      mem_arr[0]     = ins(OP_LDA, 11'h010);
      mem_arr[1]     = ins(vecs[i].op, 11'h011);
      mem_arr[2]     = ins(OP_OUT, 11'h000);
      mem_arr[3]     = ins(OP_HALT, 11'h000);
      mem_arr[11'h010] = IW'(vecs[i].a);
      mem_arr[11'h011] = IW'(vecs[i].b);
      exp_out.push_back(vecs[i].exp_r1);
      release_and_run(edges);
      check($sformatf("v%0d_edges", i), 32'(edges), 32'd14);
      check($sformatf("v%0d_r1", i), 32'(r1), 32'(vecs[i].exp_r1));
      check($sformatf("v%0d_z", i), 32'(flag_z), 32'(vecs[i].exp_z));
      check($sformatf("v%0d_c", i), 32'(flag_c), 32'(vecs[i].exp_c));
      check($sformatf("v%0d_pc", i), 32'(pc), 32'h4);
      check($sformatf("v%0d_illegal", i), 32'(illegal), 32'h0);
      if (i == 0) begin
        repeat (5) @(posedge clk);
        #1;
        check("halt_frozen_pc", 32'(pc), 32'h4);
        check("halt_frozen_req", {30'h0, mif.mem_req, halted}, 32'h1);
      end
      check($sformatf("v%0d_out_pending", i), 32'(exp_out.size()), 32'h0);
    end

    // SDL/SDH build R2, SWAP exchanges, STR writes the new R1.
    start_test();
    mem_arr[0] = ins(OP_LDA, 11'h010);
    mem_arr[1] = ins(OP_SDL, 11'h00A);
    mem_arr[2] = ins(OP_SDH, 11'h00C);
    mem_arr[3] = ins(OP_SWAP, 11'h000);
    mem_arr[4] = ins(OP_STR, 11'h030);
    mem_arr[5] = ins(OP_HALT, 11'h000);
    mem_arr[11'h010] = 16'h005A;
    exp_wr.push_back('{11'h030, 16'h00CA});
    release_and_run(edges);
    check("str_edges", 32'(edges), 32'd20);
    check("str_r1", 32'(r1), 32'hCA);
    check("str_r2", 32'(r2), 32'h5A);
    check("str_mem", 32'(mem_arr[11'h030]), 32'h00CA);
    check("str_pc", 32'(pc), 32'h6);
    check("str_wr_pending", 32'(exp_wr.size()), 32'h0);

    // SUB to zero, JZ taken to 0x020, JC not taken there.
    start_test();
    mem_arr[0] = ins(OP_LDA, 11'h010);
    mem_arr[1] = ins(OP_SUB, 11'h011);
    mem_arr[2] = ins(OP_JZ, 11'h020);
    mem_arr[11'h020] = ins(OP_JC, 11'h050);
    mem_arr[11'h021] = ins(OP_OUT, 11'h000);
    mem_arr[11'h022] = ins(OP_HALT, 11'h000);
    mem_arr[11'h010] = 16'h0040;
    mem_arr[11'h011] = 16'h0040;
    exp_out.push_back(8'h00);
    release_and_run(edges);
    check("jz_edges", 32'(edges), 32'd20);
    check("jz_pc", 32'(pc), 32'h023);
    check("jz_flags", {30'h0, flag_z, flag_c}, 32'h2);
    check("jz_out_pending", 32'(exp_out.size()), 32'h0);

    // Wait states: NOP, HALT with 0 and 3 fetch wait cycles.
    start_test();
    mem_arr[0] = ins(OP_NOP, 11'h000);
    mem_arr[1] = ins(OP_HALT, 11'h000);
    release_and_run(edges);
    check("wait0_edges", 32'(edges), 32'd6);
    start_test();
    mem_arr[0] = ins(OP_NOP, 11'h000);
    mem_arr[1] = ins(OP_HALT, 11'h000);
    wait_n = 3;
    release_and_run(edges);
    check("wait3_edges", 32'(edges), 32'd12);
    check("wait3_cycles", 32'(wait_cycles), 32'd6);
    check("wait3_stable", 32'(stab_err), 32'd0);

    // Illegal opcode: sticky flag, no register change, execution continues.
    start_test();
    mem_arr[0] = ins(OP_LDA, 11'h010);
    mem_arr[1] = ins(OP_BAD, 11'h000);
    mem_arr[2] = ins(OP_OUT, 11'h000);
    mem_arr[3] = ins(OP_HALT, 11'h000);
    mem_arr[11'h010] = 16'h0077;
    exp_out.push_back(8'h77);
    release_and_run(edges);
    check("ill_edges", 32'(edges), 32'd13);
    check("ill_flag", 32'(illegal), 32'h1);
    check("ill_regs", {16'h0, r1, r2}, 32'h7700);
    check("ill_zc", {30'h0, flag_z, flag_c}, 32'h0);
    check("ill_pc", 32'(pc), 32'h4);
    check("ill_out_pending", 32'(exp_out.size()), 32'h0);

    // pc wrap: JZ not taken, JMP 0x7FF, LDA there wraps pc to 0, JZ now taken.
    start_test();
    mem_arr[0]       = ins(OP_JZ, 11'h005);
    mem_arr[1]       = ins(OP_JMP, 11'h7FF);
    mem_arr[11'h7FF] = ins(OP_LDA, 11'h010);
    mem_arr[5]       = ins(OP_HALT, 11'h000);
    log_en = 1'b1;
    exp_addrs = '{11'h000, 11'h001, 11'h7FF, 11'h010, 11'h000, 11'h005};
    release_and_run(edges);
    check("wrap_edges", 32'(edges), 32'd16);
    check("wrap_pc", 32'(pc), 32'h6);
    check("wrap_log_len", 32'(addr_log.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < addr_log.size())
        check($sformatf("wrap_addr%0d", i), 32'(addr_log[i]), 32'(exp_addrs[i]));
    end

    // Async reset while a MEM read is stalled.
    start_test();
    mem_arr[0] = ins(OP_LDA, 11'h010);
    mem_arr[1] = ins(OP_SWAP, 11'h000);
    mem_arr[2] = ins(OP_LDA, 11'h010);
    mem_arr[3] = ins(OP_LDA, 11'h011);
    mem_arr[11'h010] = 16'h0033;
    block_en   = 1'b1;
    block_addr = 11'h011;
    @(negedge clk);
    rst_clk = 1'b1;
    edges = 0;
    while (!(mif.mem_req && mif.mem_addr == 11'h011) && edges < 200) begin
      @(posedge clk);
      #1;
      edges++;
    end
    repeat (2) @(posedge clk);
    #1;
    check("rstm_req_before", 32'(mif.mem_req), 32'h1);
    check("rstm_addr_before", 32'(mif.mem_addr), 32'h011);
    check("rstm_regs_before", {16'h0, r1, r2}, 32'h3333);
    check("rstm_pc_before", 32'(pc), 32'h4);
    @(posedge clk);
    #3;
    rst_clk = 1'b0;
    #1;
    check("rstm_req", 32'(mif.mem_req), 32'h0);
    check("rstm_pc", 32'(pc), 32'h0);
    check("rstm_regs", {16'h0, r1, r2}, 32'h0);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
